usb_txn_sched: RTL and testbench
================================

// Module: usb_txn_sched
// PURPOSE
//  Host-side transaction scheduler for the flash-over-USB host. Takes one read/write request
//  (8-bit flash addr, 64-bit data) and sequences token/data/handshake packets on the packet
//  engine (encode/stuff/NRZI/CRC below it). Handles ACK/NAK/timeout retries; one response per request.
// PARAMETERS
//  DEV_ADDR   7'd5   USB device address placed in every token
//  ADDR_EP    4'd4   endpoint receiving the flash address (OUT)
//  DATA_EP    4'd8   endpoint for flash data (OUT for write, IN for read)
//  MAX_RETRY  8      attempts per phase before the request fails
//  TIMEOUT    255    cycles from tx_done/rx end to a device response before a phase attempt fails
// PORTS
//  clk         in   1   clock
//  rst_L       in   1   asynchronous active-low reset
//  req_valid   in   1   request present
//  req_ready   out  1   scheduler idle, accepts request
//  req_write   in   1   1=write, 0=read
//  req_addr    in   8   flash address
//  req_wdata   in   64  write data
//  rsp_valid   out  1   one-cycle response pulse
//  rsp_success out  1   1=completed, 0=retries exhausted
//  rsp_rdata   out  64  read data (0 for writes and failures)
//  tx_start    out  1   one-cycle launch of a packet to engine
//  tx_pid      out  4   OUT=0001 IN=1001 DATA0=0011 ACK=0010 NAK=1010
//  tx_endp     out  4   token endpoint (addr fixed DEV_ADDR on tx_addr)
//  tx_addr     out  7   token device address
//  tx_data     out  64  DATA0 payload (address phase: {56'b0,addr})
//  tx_busy     in   1   engine transmitting; tx_start only when 0
//  tx_done     in   1   one-cycle pulse at end of packet EOP
//  rx_valid    in   1   one-cycle pulse: packet received
//  rx_pid      in   4   received PID
//  rx_data     in   64  received payload
//  rx_crc_ok   in   1   CRC16 of received data packet correct
// BEHAVIOUR
//  Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_success=0, rsp_rdata=0, tx_start=0,
//   tx_pid/endp/data=0, retry and timeout counters 0. Reset mid-transaction aborts, no response.
//  Accept: req_valid&&req_ready latches write/addr/wdata; req_ready drops next cycle.
//  States: IDLE, A_TOK, A_DAT, A_WAIT, W_TOK, W_DAT, W_WAIT, R_TOK, R_WAIT, R_HS, RESP.
//  *_TOK/*_DAT/R_HS: assert tx_start one cycle (when !tx_busy), hold fields stable until tx_done;
//   TOK->DAT on tx_done (OUT token then DATA0), DAT->WAIT on tx_done.
//  A_WAIT/W_WAIT: rx_valid&&rx_pid==ACK -> next phase (A->W_TOK if write, A->R_TOK if read;
//   W->RESP success). NAK, other PID, or TIMEOUT cycles with no rx_valid -> attempt failed.
//  R_TOK: IN token to DATA_EP, ->R_WAIT on tx_done. R_WAIT: DATA0 with rx_crc_ok -> latch
//   rx_data, R_HS sends ACK, then RESP success. DATA0 bad CRC -> R_HS sends NAK, attempt failed
//   after its tx_done. Device NAK or timeout -> attempt failed (no handshake sent).
//  Failed attempt: retry_cnt+1; if <MAX_RETRY restart at the phase's TOK state, else RESP fail.
//  retry_cnt clears on entering each phase (address, write-data, read-data) -> budget per phase.
//  Timeout counter clears on tx_done, counts in WAIT states; fail when count==TIMEOUT.
//  rx_valid outside WAIT states ignored; rx_valid same cycle as timeout -> rx_valid wins.
//  RESP: rsp_valid=1 one cycle, rsp_success/rsp_rdata valid that cycle; -> IDLE, req_ready=1 next.
//  Latency: response 1 cycle after last required tx_done/rx_valid; no request overlap.
// TESTING
//  Write 0xAB/0xCAFEBABEDEADBEEF, device ACKs all -> tx seq OUT(4),DATA0(0xAB),OUT(4),
//   DATA0(CAFEBABEDEADBEEF); rsp success=1, rdata=0.
//  Read 0xAB, device returns DATA0 0xCAFEBABEDEADBEEF crc ok -> OUT(4),DATA0,IN(8),ACK;
//   rsp success=1, rdata=CAFEBABEDEADBEEF.
//  Read with bad CRC twice then good -> NAK sent twice, 3 IN tokens, success=1.
//  Write address phase NAKed 8 times -> 8 OUT(4) tokens, no data-phase token, rsp success=0.
//  No device response on write-data phase -> retry after exactly 255 idle cycles, fail after 8.
//  rst_L low during R_WAIT -> all outputs reset immediately, req_ready=1, no rsp_valid.

Source files
------------

// File: rtl/usb_txn_sched_if.sv
// Request/response and packet-engine signals of the USB transaction scheduler.
// The scheduler connects through the slave modport; the client/engine side uses master.
interface usb_txn_sched_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_success;
    logic [63:0] rsp_rdata;
    logic        tx_start;
    logic [3:0]  tx_pid;
    logic [3:0]  tx_endp;
    logic [6:0]  tx_addr;
    logic [63:0] tx_data;
    logic        tx_busy;
    logic        tx_done;
    logic        rx_valid;
    logic [3:0]  rx_pid;
    logic [63:0] rx_data;
    logic        rx_crc_ok;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  tx_busy, tx_done, rx_valid, rx_pid, rx_data, rx_crc_ok,
        output req_ready, rsp_valid, rsp_success, rsp_rdata,
        output tx_start, tx_pid, tx_endp, tx_addr, tx_data
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output tx_busy, tx_done, rx_valid, rx_pid, rx_data, rx_crc_ok,
        input  req_ready, rsp_valid, rsp_success, rsp_rdata,
        input  tx_start, tx_pid, tx_endp, tx_addr, tx_data
    );
endinterface

// File: rtl/usb_txn_sched.sv
// Host-side USB transaction scheduler: turns one flash read/write request into
// token/data/handshake packets with per-phase retry and response timeout.
module usb_txn_sched #(
    parameter logic [6:0] DEV_ADDR  = 7'd5,
    parameter logic [3:0] ADDR_EP   = 4'd4,
    parameter logic [3:0] DATA_EP   = 4'd8,
    parameter int         MAX_RETRY = 8,
    parameter int         TIMEOUT   = 255
) (
    input  logic           clk,
    input  logic           rst_L,
    usb_txn_sched_if.slave bus
);
    localparam logic [3:0] PID_OUT    = 4'b0001;
    localparam logic [3:0] PID_IN     = 4'b1001;
    localparam logic [3:0] PID_DATA0  = 4'b0011;
    localparam logic [3:0] PID_ACK    = 4'b0010;
    localparam logic [3:0] PID_NAK    = 4'b1010;
    localparam logic [3:0] RETRY_LAST = 4'(MAX_RETRY - 1);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, A_TOK, A_DAT, A_WAIT, W_TOK, W_DAT, W_WAIT, R_TOK, R_WAIT, R_HS, RESP
    } state_t;

    state_t      state_r;
    logic        write_r;
    logic [7:0]  addr_r;
    logic [63:0] wdata_r;
    logic [63:0] rdata_r;
    logic [3:0]  retry_r;
    logic [7:0]  tmo_r;
    logic        sent_r;
    logic        hs_nak_r;
    logic        req_ready_r;
    logic        rsp_valid_r;
    logic        rsp_success_r;
    logic [63:0] rsp_rdata_r;
    logic        tx_start_r;
    logic [3:0]  tx_pid_r;
    logic [3:0]  tx_endp_r;
    logic [6:0]  tx_addr_r;
    logic [63:0] tx_data_r;

    logic [3:0]  pkt_pid_s;
    logic [3:0]  pkt_endp_s;
    logic [63:0] pkt_data_s;
    state_t      pkt_next_s;
    state_t      retry_tok_s;
    logic        ack_s;
    logic        tmo_hit_s;
    logic        tx_end_s;
    logic        fail_s;
    logic        done_ok_s;

    assign bus.req_ready   = req_ready_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_success = rsp_success_r;
    assign bus.rsp_rdata   = rsp_rdata_r;
    assign bus.tx_start    = tx_start_r;
    assign bus.tx_pid      = tx_pid_r;
    assign bus.tx_endp     = tx_endp_r;
    assign bus.tx_addr     = tx_addr_r;
    assign bus.tx_data     = tx_data_r;

    // Packet to launch in the current state and the outcome of the current attempt.
    always_comb begin
        pkt_pid_s   = PID_OUT;
        pkt_endp_s  = 4'd0;
        pkt_data_s  = 64'd0;
        pkt_next_s  = IDLE;
        retry_tok_s = A_TOK;
        fail_s      = 1'b0;
        done_ok_s   = 1'b0;
        ack_s       = bus.rx_valid && (bus.rx_pid == PID_ACK);
        // A response arriving in the timeout cycle takes priority over the timeout.
        tmo_hit_s   = !bus.rx_valid && (tmo_r == TMO_LAST);
        tx_end_s    = sent_r && bus.tx_done;
        case (state_r)
            A_TOK: begin
                pkt_pid_s  = PID_OUT;
                pkt_endp_s = ADDR_EP;
                pkt_next_s = A_DAT;
            end
            A_DAT: begin
                pkt_pid_s  = PID_DATA0;
                pkt_data_s = {56'd0, addr_r};
                pkt_next_s = A_WAIT;
            end
            A_WAIT: begin
                retry_tok_s = A_TOK;
                fail_s      = (bus.rx_valid && !ack_s) || tmo_hit_s;
            end
            W_TOK: begin
                pkt_pid_s  = PID_OUT;
                pkt_endp_s = DATA_EP;
                pkt_next_s = W_DAT;
            end
            W_DAT: begin
                pkt_pid_s  = PID_DATA0;
                pkt_data_s = wdata_r;
                pkt_next_s = W_WAIT;
            end
            W_WAIT: begin
                retry_tok_s = W_TOK;
                fail_s      = (bus.rx_valid && !ack_s) || tmo_hit_s;
                done_ok_s   = ack_s;
            end
            R_TOK: begin
                pkt_pid_s  = PID_IN;
                pkt_endp_s = DATA_EP;
                pkt_next_s = R_WAIT;
            end
            R_WAIT: begin
                retry_tok_s = R_TOK;
                fail_s      = (bus.rx_valid && (bus.rx_pid != PID_DATA0)) || tmo_hit_s;
            end
            R_HS: begin
                pkt_pid_s   = hs_nak_r ? PID_NAK : PID_ACK;
                pkt_next_s  = RESP;
                retry_tok_s = R_TOK;
                fail_s      = tx_end_s && hs_nak_r;
                done_ok_s   = tx_end_s && !hs_nak_r;
            end
            default: begin
                pkt_next_s = IDLE;
            end
        endcase
    end

    // Transaction FSM with registered request, packet and response outputs.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_r       <= IDLE;
            write_r       <= 1'b0;
            addr_r        <= 8'd0;
            wdata_r       <= 64'd0;
            rdata_r       <= 64'd0;
            retry_r       <= 4'd0;
            tmo_r         <= 8'd0;
            sent_r        <= 1'b0;
            hs_nak_r      <= 1'b0;
            req_ready_r   <= 1'b1;
            rsp_valid_r   <= 1'b0;
            rsp_success_r <= 1'b0;
            rsp_rdata_r   <= 64'd0;
            tx_start_r    <= 1'b0;
            tx_pid_r      <= 4'd0;
            tx_endp_r     <= 4'd0;
            tx_addr_r     <= 7'd0;
            tx_data_r     <= 64'd0;
        end else begin
            tx_start_r  <= 1'b0;
            rsp_valid_r <= 1'b0;
            if (fail_s) begin
                sent_r <= 1'b0;
                tmo_r  <= 8'd0;
                if (retry_r == RETRY_LAST) begin
                    state_r       <= RESP;
                    rsp_valid_r   <= 1'b1;
                    rsp_success_r <= 1'b0;
                    rsp_rdata_r   <= 64'd0;
                end else begin
                    retry_r <= retry_r + 4'd1;
                    state_r <= retry_tok_s;
                end
            end else if (done_ok_s) begin
                sent_r        <= 1'b0;
                state_r       <= RESP;
                rsp_valid_r   <= 1'b1;
                rsp_success_r <= 1'b1;
                rsp_rdata_r   <= write_r ? 64'd0 : rdata_r;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (bus.req_valid && req_ready_r) begin
                            write_r     <= bus.req_write;
                            addr_r      <= bus.req_addr;
                            wdata_r     <= bus.req_wdata;
                            rdata_r     <= 64'd0;
                            retry_r     <= 4'd0;
                            req_ready_r <= 1'b0;
                            state_r     <= A_TOK;
                        end
                    end
                    A_TOK, A_DAT, W_TOK, W_DAT, R_TOK, R_HS: begin
                        if (!sent_r) begin
                            if (!bus.tx_busy) begin
                                tx_start_r <= 1'b1;
                                sent_r     <= 1'b1;
                                tx_pid_r   <= pkt_pid_s;
                                tx_endp_r  <= pkt_endp_s;
                                tx_addr_r  <= DEV_ADDR;
                                tx_data_r  <= pkt_data_s;
                            end
                        end else if (bus.tx_done) begin
                            sent_r  <= 1'b0;
                            tmo_r   <= 8'd0;
                            state_r <= pkt_next_s;
                        end
                    end
                    A_WAIT: begin
                        if (ack_s) begin
                            retry_r <= 4'd0;
                            state_r <= write_r ? W_TOK : R_TOK;
                        end else begin
                            tmo_r <= tmo_r + 8'd1;
                        end
                    end
                    W_WAIT: begin
                        tmo_r <= tmo_r + 8'd1;
                    end
                    R_WAIT: begin
                        if (bus.rx_valid) begin
                            hs_nak_r <= !bus.rx_crc_ok;
                            rdata_r  <= bus.rx_crc_ok ? bus.rx_data : rdata_r;
                            state_r  <= R_HS;
                        end else begin
                            tmo_r <= tmo_r + 8'd1;
                        end
                    end
                    RESP: begin
                        state_r       <= IDLE;
                        req_ready_r   <= 1'b1;
                        rsp_success_r <= 1'b0;
                        rsp_rdata_r   <= 64'd0;
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_usb_txn_sched.sv
// Directed bench for usb_txn_sched: a behavioural packet engine plus device model
// answers the scheduler, and each test task checks the packet log and response.
module tb_usb_txn_sched;
    localparam logic [3:0] P_OUT = 4'b0001;
    localparam logic [3:0] P_IN  = 4'b1001;
    localparam logic [3:0] P_D0  = 4'b0011;
    localparam logic [3:0] P_ACK = 4'b0010;
    localparam logic [3:0] P_NAK = 4'b1010;

    logic clk   = 1'b0;
    logic rst_L = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    usb_txn_sched_if bus ();

    usb_txn_sched dut (
        .clk   (clk),
        .rst_L (rst_L),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // packet log written by the engine; tests read it from pkt0 onward
    logic [3:0]  log_pid  [$];
    logic [3:0]  log_endp [$];
    logic [6:0]  log_addr [$];
    logic [63:0] log_data [$];
    int          log_start[$];
    int          log_done [$];
    int          pkt0 = 0;

    // device behaviour knobs
    int          addr_nak_left = 0;
    int          crc_bad_left  = 0;
    bit          wdat_silent   = 1'b0;
    bit          in_silent     = 1'b0;
    int          resp_dly      = 2;
    logic [63:0] dev_rdata     = 64'd0;

    int          rsp_cnt = 0;
    logic        rsp_succ_cap;
    logic [63:0] rsp_rdata_cap;

    function automatic int n_pkts();
        return log_pid.size() - pkt0;
    endfunction

    function automatic int count_tok(input logic [3:0] p, input logic [3:0] ep);
        int c = 0;
        for (int i = pkt0; i < log_pid.size(); i++)
            if (log_pid[i] == p && log_endp[i] == ep) c++;
        return c;
    endfunction

    function automatic int count_pid(input logic [3:0] p);
        int c = 0;
        for (int i = pkt0; i < log_pid.size(); i++)
            if (log_pid[i] == p) c++;
        return c;
    endfunction

    // packet engine (3 busy cycles then tx_done) and USB device model
    initial begin
        logic [3:0]  e_pid;
        logic [3:0]  last_endp;
        logic [3:0]  r_pid;
        logic [63:0] r_data;
        logic        r_crc;
        bit          send;
        bus.tx_busy = 1'b0; bus.tx_done = 1'b0; bus.rx_valid = 1'b0;
        bus.rx_pid = 4'd0;  bus.rx_data = 64'd0; bus.rx_crc_ok = 1'b0;
        last_endp = 4'd0;
        forever begin
            @(negedge clk);
            if (rst_L && bus.tx_start) begin
                e_pid = bus.tx_pid;
                log_pid.push_back(bus.tx_pid);
                log_endp.push_back(bus.tx_endp);
                log_addr.push_back(bus.tx_addr);
                log_data.push_back(bus.tx_data);
                log_start.push_back(cyc);
                if (e_pid == P_OUT || e_pid == P_IN) last_endp = bus.tx_endp;
                bus.tx_busy = 1'b1;
                repeat (3) @(negedge clk);
                bus.tx_busy = 1'b0;
                bus.tx_done = 1'b1;
                log_done.push_back(cyc);
                @(negedge clk);
                bus.tx_done = 1'b0;
                send = 1'b0; r_pid = P_ACK; r_data = 64'd0; r_crc = 1'b1;
                if (e_pid == P_IN) begin
                    if (!in_silent) begin
                        send = 1'b1; r_pid = P_D0; r_data = dev_rdata;
                        r_crc = (crc_bad_left == 0);
                        if (crc_bad_left > 0) crc_bad_left = crc_bad_left - 1;
                    end
                end else if (e_pid == P_D0) begin
                    if (last_endp == 4'd4) begin
                        send = 1'b1;
                        if (addr_nak_left > 0) begin
                            r_pid = P_NAK; addr_nak_left = addr_nak_left - 1;
                        end
                    end else if (!wdat_silent) begin
                        send = 1'b1;
                    end
                end
                if (send) begin
                    repeat (resp_dly - 1) @(negedge clk);
                    bus.rx_valid = 1'b1; bus.rx_pid = r_pid;
                    bus.rx_data = r_data; bus.rx_crc_ok = r_crc;
                    @(negedge clk);
                    bus.rx_valid = 1'b0;
                end
            end
        end
    end

    // response monitor
    initial begin
        forever begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                rsp_cnt = rsp_cnt + 1;
                rsp_succ_cap = bus.rsp_success;
                rsp_rdata_cap = bus.rsp_rdata;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_request(input logic wr, input logic [7:0] addr, input logic [63:0] wdata,
                              output bit got, output logic succ, output logic [63:0] rdata,
                              output logic rdy_busy, output logic rdy_after, output logic pulse_after);
        int base;
        int n;
        pkt0 = log_pid.size();
        base = rsp_cnt;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr; bus.req_wdata = wdata;
        @(negedge clk);
        bus.req_valid = 1'b0;
        rdy_busy = bus.req_ready;
        n = 0;
        while (rsp_cnt == base && n < 8000) begin
            @(negedge clk); #1; n++;
        end
        got = (rsp_cnt != base);
        succ = rsp_succ_cap;
        rdata = rsp_rdata_cap;
        @(negedge clk); #1;
        rdy_after = bus.req_ready;
        pulse_after = bus.rsp_valid;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_success, bus.tx_start} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl: ready/rsp_valid/success/tx_start=%b expected 1000",
                     {bus.req_ready, bus.rsp_valid, bus.rsp_success, bus.tx_start});
        end
        checks++;
        if ({bus.tx_pid, bus.tx_endp, bus.tx_data, bus.rsp_rdata} !== 136'd0) begin
            errors++;
            $display("FAIL reset_fields: pid=%h endp=%h data=%h rdata=%h expected all 0",
                     bus.tx_pid, bus.tx_endp, bus.tx_data, bus.rsp_rdata);
        end
        rst_L = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%b expected 1", bus.req_ready);
        end
    endtask

    task automatic test_write;
        logic [3:0] exp_pid [4];
        logic [3:0] exp_ep [4];
        logic [63:0] exp_dat [4];
        bit got; logic succ, rb, ra, pa; logic [63:0] rd;
        exp_pid = '{P_OUT, P_D0, P_OUT, P_D0};
        exp_ep  = '{4'd4, 4'd0, 4'd8, 4'd0};
        exp_dat = '{64'd0, 64'h00000000000000AB, 64'd0, 64'hCAFEBABEDEADBEEF};
        do_request(1'b1, 8'hAB, 64'hCAFEBABEDEADBEEF, got, succ, rd, rb, ra, pa);
        checks++;
        if (!got || succ !== 1'b1 || rd !== 64'd0) begin
            errors++;
            $display("FAIL write_rsp: got=%0d success=%b rdata=%h expected 1/1/0", got, succ, rd);
        end
        checks++;
        if ({rb, ra, pa} !== 3'b010) begin
            errors++;
            $display("FAIL write_ready: busy_ready=%b ready_after=%b rsp_after=%b expected 0/1/0", rb, ra, pa);
        end
        checks++;
        if (n_pkts() !== 4) begin
            errors++;
            $display("FAIL write_npkts: %0d packets expected 4", n_pkts());
        end
        for (int i = 0; i < 4 && i < n_pkts(); i++) begin
            checks++;
            if (log_pid[pkt0+i] !== exp_pid[i] ||
                (exp_pid[i] == P_OUT && (log_endp[pkt0+i] !== exp_ep[i] || log_addr[pkt0+i] !== 7'd5)) ||
                (exp_pid[i] == P_D0 && log_data[pkt0+i] !== exp_dat[i])) begin
                errors++;
                $display("FAIL write_pkt%0d: pid=%h endp=%h addr=%h data=%h expected pid=%h endp=%h addr=05 data=%h",
                         i, log_pid[pkt0+i], log_endp[pkt0+i], log_addr[pkt0+i], log_data[pkt0+i],
                         exp_pid[i], exp_ep[i], exp_dat[i]);
            end
        end
    endtask

    task automatic test_read;
        logic [3:0] exp_pid [4];
        bit got; logic succ, rb, ra, pa; logic [63:0] rd;
        exp_pid = '{P_OUT, P_D0, P_IN, P_ACK};
        dev_rdata = 64'hCAFEBABEDEADBEEF;
        do_request(1'b0, 8'hAB, 64'h1111111111111111, got, succ, rd, rb, ra, pa);
        checks++;
        if (!got || succ !== 1'b1 || rd !== 64'hCAFEBABEDEADBEEF) begin
            errors++;
            $display("FAIL read_rsp: got=%0d success=%b rdata=%h expected 1/1/cafebabedeadbeef", got, succ, rd);
        end
        checks++;
        if (n_pkts() !== 4) begin
            errors++;
            $display("FAIL read_npkts: %0d packets expected 4", n_pkts());
        end
        for (int i = 0; i < 4 && i < n_pkts(); i++) begin
            checks++;
            if (log_pid[pkt0+i] !== exp_pid[i]) begin
                errors++;
                $display("FAIL read_pkt%0d: pid=%h expected %h", i, log_pid[pkt0+i], exp_pid[i]);
            end
        end
        checks++;
        if (count_tok(P_IN, 4'd8) !== 1 || log_data[pkt0+1] !== 64'h00000000000000AB) begin
            errors++;
            $display("FAIL read_fields: IN(8) tokens=%0d addr payload=%h expected 1/ab",
                     count_tok(P_IN, 4'd8), log_data[pkt0+1]);
        end
    endtask

    task automatic test_read_crc_retry;
        logic [3:0] exp_pid [8];
        bit got; logic succ, rb, ra, pa; logic [63:0] rd;
        exp_pid = '{P_OUT, P_D0, P_IN, P_NAK, P_IN, P_NAK, P_IN, P_ACK};
        dev_rdata = 64'h0123456789ABCDEF;
        crc_bad_left = 2;
        do_request(1'b0, 8'h3C, 64'd0, got, succ, rd, rb, ra, pa);
        checks++;
        if (!got || succ !== 1'b1 || rd !== 64'h0123456789ABCDEF) begin
            errors++;
            $display("FAIL crc_rsp: got=%0d success=%b rdata=%h expected 1/1/0123456789abcdef", got, succ, rd);
        end
        checks++;
        if (n_pkts() !== 8 || count_pid(P_IN) !== 3 || count_pid(P_NAK) !== 2) begin
            errors++;
            $display("FAIL crc_counts: pkts=%0d IN=%0d NAK=%0d expected 8/3/2",
                     n_pkts(), count_pid(P_IN), count_pid(P_NAK));
        end
        for (int i = 0; i < 8 && i < n_pkts(); i++) begin
            checks++;
            if (log_pid[pkt0+i] !== exp_pid[i]) begin
                errors++;
                $display("FAIL crc_pkt%0d: pid=%h expected %h", i, log_pid[pkt0+i], exp_pid[i]);
            end
        end
    endtask

    // 7 address NAKs and 7 bad-CRC reads: each phase has its own budget of 8 attempts
    task automatic test_phase_budget;
        bit got; logic succ, rb, ra, pa; logic [63:0] rd;
        dev_rdata = 64'h5A5A00FF00FFA5A5;
        addr_nak_left = 7;
        crc_bad_left = 7;
        do_request(1'b0, 8'h01, 64'd0, got, succ, rd, rb, ra, pa);
        checks++;
        if (!got || succ !== 1'b1 || rd !== 64'h5A5A00FF00FFA5A5) begin
            errors++;
            $display("FAIL budget_rsp: got=%0d success=%b rdata=%h expected 1/1/5a5a00ff00ffa5a5", got, succ, rd);
        end
        checks++;
        if (n_pkts() !== 32 || count_tok(P_OUT, 4'd4) !== 8 || count_pid(P_IN) !== 8) begin
            errors++;
            $display("FAIL budget_counts: pkts=%0d OUT(4)=%0d IN=%0d expected 32/8/8",
                     n_pkts(), count_tok(P_OUT, 4'd4), count_pid(P_IN));
        end
    endtask

    task automatic test_addr_nak;
        bit got; logic succ, rb, ra, pa; logic [63:0] rd;
        addr_nak_left = 8;
        do_request(1'b1, 8'h77, 64'hFFFF0000FFFF0000, got, succ, rd, rb, ra, pa);
        checks++;
        if (!got || succ !== 1'b0 || rd !== 64'd0) begin
            errors++;
            $display("FAIL nak_rsp: got=%0d success=%b rdata=%h expected 1/0/0", got, succ, rd);
        end
        checks++;
        if (n_pkts() !== 16 || count_tok(P_OUT, 4'd4) !== 8 || count_tok(P_OUT, 4'd8) !== 0) begin
            errors++;
            $display("FAIL nak_counts: pkts=%0d OUT(4)=%0d OUT(8)=%0d expected 16/8/0",
                     n_pkts(), count_tok(P_OUT, 4'd4), count_tok(P_OUT, 4'd8));
        end
        checks++;
        if ({ra, pa} !== 2'b10) begin
            errors++;
            $display("FAIL nak_ready: ready_after=%b rsp_after=%b expected 1/0", ra, pa);
        end
        addr_nak_left = 0;
    endtask

    // silent write-data phase: 255 wait cycles, one W_TOK cycle, then the registered
    // tx_start, so the retry token shows 257 cycles after the data tx_done
    task automatic test_timeout;
        bit got; logic succ, rb, ra, pa; logic [63:0] rd;
        int gap;
        wdat_silent = 1'b1;
        do_request(1'b1, 8'h42, 64'h0F0F0F0F0F0F0F0F, got, succ, rd, rb, ra, pa);
        wdat_silent = 1'b0;
        checks++;
        if (!got || succ !== 1'b0 || rd !== 64'd0) begin
            errors++;
            $display("FAIL tmo_rsp: got=%0d success=%b rdata=%h expected 1/0/0", got, succ, rd);
        end
        checks++;
        if (n_pkts() !== 18 || count_tok(P_OUT, 4'd8) !== 8) begin
            errors++;
            $display("FAIL tmo_counts: pkts=%0d OUT(8)=%0d expected 18/8", n_pkts(), count_tok(P_OUT, 4'd8));
        end
        gap = (n_pkts() > 4) ? (log_start[pkt0+4] - log_done[pkt0+3]) : -1;
        checks++;
        if (gap !== 257) begin
            errors++;
            $display("FAIL tmo_gap: retry token %0d cycles after data tx_done expected 257", gap);
        end
    endtask

    // ACK arriving in the very cycle the timeout expires must still be taken
    task automatic test_timeout_edge;
        bit got; logic succ, rb, ra, pa; logic [63:0] rd;
        resp_dly = 255;
        do_request(1'b1, 8'h99, 64'h8877665544332211, got, succ, rd, rb, ra, pa);
        resp_dly = 2;
        checks++;
        if (!got || succ !== 1'b1 || n_pkts() !== 4) begin
            errors++;
            $display("FAIL tmo_edge: got=%0d success=%b pkts=%0d expected 1/1/4", got, succ, n_pkts());
        end
    endtask

    task automatic test_reset_mid;
        int base;
        int n;
        int pkts_at_rst;
        in_silent = 1'b1;
        pkt0 = log_pid.size();
        base = rsp_cnt;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 8'h11; bus.req_wdata = 64'd0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (count_pid(P_IN) == 0 && n < 200) begin
            @(negedge clk); n++;
        end
        checks++;
        if (count_pid(P_IN) !== 1) begin
            errors++;
            $display("FAIL rstmid_in: IN tokens=%0d expected 1", count_pid(P_IN));
        end
        repeat (20) @(negedge clk);
        #2;
        rst_L = 1'b0;
        #1;
        pkts_at_rst = log_pid.size();
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_success, bus.tx_start} !== 4'b1000 ||
            {bus.tx_pid, bus.tx_endp, bus.tx_data, bus.rsp_rdata} !== 136'd0) begin
            errors++;
            $display("FAIL rstmid_out: ready/rsp/succ/start=%b pid=%h endp=%h data=%h expected 1000 and zeros",
                     {bus.req_ready, bus.rsp_valid, bus.rsp_success, bus.tx_start},
                     bus.tx_pid, bus.tx_endp, bus.tx_data);
        end
        @(negedge clk);
        rst_L = 1'b1;
        in_silent = 1'b0;
        repeat (300) @(negedge clk);
        checks++;
        if (rsp_cnt !== base || log_pid.size() !== pkts_at_rst || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_quiet: responses=%0d new_pkts=%0d ready=%b expected 0/0/1",
                     rsp_cnt - base, log_pid.size() - pkts_at_rst, bus.req_ready);
        end
    endtask

    task automatic test_back_to_back;
        bit got; logic succ, rb, ra, pa; logic [63:0] rd;
        dev_rdata = 64'hDEADBEEF00C0FFEE;
        do_request(1'b0, 8'h00, 64'd0, got, succ, rd, rb, ra, pa);
        checks++;
        if (!got || succ !== 1'b1 || rd !== 64'hDEADBEEF00C0FFEE || {rb, ra} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_read: got=%0d success=%b rdata=%h ready=%b%b expected 1/1/deadbeef00c0ffee/01",
                     got, succ, rd, rb, ra);
        end
        do_request(1'b1, 8'hFF, 64'h0000000000000001, got, succ, rd, rb, ra, pa);
        checks++;
        if (!got || succ !== 1'b1 || rd !== 64'd0 || n_pkts() !== 4 || log_data[pkt0+1] !== 64'h00000000000000FF) begin
            errors++;
            $display("FAIL b2b_write: got=%0d success=%b rdata=%h pkts=%0d addr payload=%h expected 1/1/0/4/ff",
                     got, succ, rd, n_pkts(), log_data[pkt0+1]);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'd0;
        bus.req_wdata = 64'd0;
        test_reset;
        test_write;
        test_read;
        test_read_crc_retry;
        test_phase_budget;
        test_addr_nak;
        test_timeout;
        test_timeout_edge;
        test_reset_mid;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
